// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle for hazard_ctrl_unit: ID/EX/MEM/WB status in, latch control out.
// slave = the controller, master = the pipeline datapath driving status.
interface hazard_ctrl_unit_if #(
   parameter int DEPTH = 2,
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   localparam int FW = $clog2(DEPTH + 1);

   logic             ihit;
   logic             dhit;
   logic             mem_dREN;
   logic             mem_dWEN;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_regwr;
   logic [REG_W-1:0] id_dst;
   logic             id_load;
   logic             ex_taken;
   logic             wb_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic [FW-1:0]    fwd_a;
   logic [FW-1:0]    fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic             halted;

   modport slave (
      input  ihit, dhit, mem_dREN, mem_dWEN, id_rs, id_rt, id_use_rs, id_use_rt,
             id_regwr, id_dst, id_load, ex_taken, wb_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             fwd_a, fwd_b, stall_cnt, halted
   );

   modport master (
      output ihit, dhit, mem_dREN, mem_dWEN, id_rs, id_rt, id_use_rs, id_use_rt,
             id_regwr, id_dst, id_load, ex_taken, wb_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             fwd_a, fwd_b, stall_cnt, halted
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: write scoreboard, RAW/load-use stalls, memory stalls, branch flush, halt.
// HAZARD_FORWARDING_EN defined: stall only on load-use and drive fwd_a/fwd_b; undefined: stall on any RAW.
module hazard_ctrl_unit #(
   parameter int DEPTH = 2,
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input logic                CLK,
   input logic                RST,
   hazard_ctrl_unit_if.slave  hz
);
   localparam int FW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] sb_vld;
   logic [DEPTH-1:0] sb_load;
   logic [REG_W-1:0] sb_dst [DEPTH];
   logic [CNT_W-1:0] cnt_q;
   logic             halted_q;

   logic [DEPTH-1:0] m_rs;
   logic [DEPTH-1:0] m_rt;
   logic             hazard;
   logic             mem_stall;
   logic             advance;
   logic             bubble;
   logic             new_vld;
   logic [FW-1:0]    fa_raw;
   logic [FW-1:0]    fb_raw;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         m_rs[k] = hz.id_use_rs && sb_vld[k] && (sb_dst[k] == hz.id_rs);
         m_rt[k] = hz.id_use_rt && sb_vld[k] && (sb_dst[k] == hz.id_rt);
      end
   end

`ifdef HAZARD_FORWARDING_EN
   // A load still in EX has no data yet; every other producer can be forwarded.
   assign hazard = sb_load[0] && (m_rs[0] || m_rt[0]);

   always_comb begin
      fa_raw = '0;
      fb_raw = '0;
      // Walk oldest to youngest so the youngest match is written last.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (m_rs[k] && !(k == 0 && sb_load[0])) fa_raw = FW'(k + 1);
         if (m_rt[k] && !(k == 0 && sb_load[0])) fb_raw = FW'(k + 1);
      end
   end
`else
   assign hazard = |{m_rs, m_rt};
   assign fa_raw = '0;
   assign fb_raw = '0;
`endif

   assign mem_stall = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
   assign advance   = !halted_q && !mem_stall;
   assign bubble    = hz.ex_taken || hazard;
   assign new_vld   = hz.id_regwr && (hz.id_dst != '0) && !bubble;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sb_vld  <= '0;
         sb_load <= '0;
         for (int k = 0; k < DEPTH; k++) sb_dst[k] <= '0;
      end else if (advance) begin
         sb_vld[0]  <= new_vld;
         sb_load[0] <= hz.id_load && !bubble;
         sb_dst[0]  <= hz.id_dst;
         for (int k = 1; k < DEPTH; k++) begin
            sb_vld[k]  <= sb_vld[k-1];
            sb_load[k] <= sb_load[k-1];
            sb_dst[k]  <= sb_dst[k-1];
         end
      end
   end

   // Only cycles actually lost to a data hazard are counted; a branch squash wins over it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (advance && !hz.ex_taken && hazard && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         halted_q <= 1'b0;
      end else if (hz.wb_halt) begin
         halted_q <= 1'b1;
      end
   end

   assign hz.stall_cnt = cnt_q;
   assign hz.halted    = halted_q;

   always_comb begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.idex_en    = 1'b0;
      hz.exmem_en   = 1'b0;
      hz.memwb_en   = 1'b0;
      hz.ifid_flush = 1'b0;
      hz.idex_flush = 1'b0;
      hz.fwd_a      = '0;
      hz.fwd_b      = '0;
      if (RST) begin
         hz.ifid_flush = 1'b1;
         hz.idex_flush = 1'b1;
      end else begin
         hz.fwd_a = fa_raw;
         hz.fwd_b = fb_raw;
         if (advance) begin
            if (hz.ex_taken) begin
               hz.pc_en      = 1'b1;
               hz.ifid_en    = 1'b1;
               hz.idex_en    = 1'b1;
               hz.exmem_en   = 1'b1;
               hz.memwb_en   = 1'b1;
               hz.ifid_flush = 1'b1;
               hz.idex_flush = 1'b1;
            end else if (hazard) begin
               hz.idex_en    = 1'b1;
               hz.exmem_en   = 1'b1;
               hz.memwb_en   = 1'b1;
               hz.idex_flush = 1'b1;
            end else if (!hz.ihit) begin
               hz.ifid_en    = 1'b1;
               hz.idex_en    = 1'b1;
               hz.exmem_en   = 1'b1;
               hz.memwb_en   = 1'b1;
               hz.ifid_flush = 1'b1;
            end else begin
               hz.pc_en      = 1'b1;
               hz.ifid_en    = 1'b1;
               hz.idex_en    = 1'b1;
               hz.exmem_en   = 1'b1;
               hz.memwb_en   = 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (DEPTH=2, REG_W=5, CNT_W=4 so saturation is reachable quickly).
// Control outputs are compared as {pc_en,ifid_en,idex_en,exmem_en,memwb_en,ifid_flush,idex_flush}.
module tb_hazard_ctrl_unit;
   localparam int DEPTH = 2;
   localparam int REG_W = 5;
   localparam int CNT_W = 4;

   localparam logic [6:0] RUN   = 7'b1111100;
   localparam logic [6:0] STALL = 7'b0011101;
   localparam logic [6:0] HOLD  = 7'b0000000;
   localparam logic [6:0] RSTV  = 7'b0000011;
   localparam logic [6:0] BR    = 7'b1111111;
   localparam logic [6:0] NOI   = 7'b0111110;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   logic [6:0] en;

   hazard_ctrl_unit_if #(.DEPTH(DEPTH), .REG_W(REG_W), .CNT_W(CNT_W)) hz ();

   hazard_ctrl_unit #(.DEPTH(DEPTH), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK (clk),
      .RST (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   assign en = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.ihit      = 1'b1;
      hz.dhit      = 1'b1;
      hz.mem_dREN  = 1'b0;
      hz.mem_dWEN  = 1'b0;
      hz.id_rs     = '0;
      hz.id_rt     = '0;
      hz.id_use_rs = 1'b0;
      hz.id_use_rt = 1'b0;
      hz.id_regwr  = 1'b0;
      hz.id_dst    = '0;
      hz.id_load   = 1'b0;
      hz.ex_taken  = 1'b0;
      hz.wb_halt   = 1'b0;
   endtask

   task automatic producer(input logic [REG_W-1:0] dst, input logic ld);
      idle();
      hz.id_regwr = 1'b1;
      hz.id_dst   = dst;
      hz.id_load  = ld;
   endtask

   task automatic drain();
      idle();
      repeat (3) cyc();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #2;
      chk("reset_en", en, RSTV);
      chk("reset_cnt", hz.stall_cnt, 0);
      chk("reset_halted", hz.halted, 0);
      chk("reset_fwd", {hz.fwd_a, hz.fwd_b}, 0);
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk("run_after_reset", en, RUN);

      // add r3 ; sub rs=r3
      cyc();
      producer(5'd3, 1'b0);
      #1 chk("alu_producer", en, RUN);
      cyc();
      idle();
      hz.id_use_rs = 1'b1; hz.id_rs = 5'd3; hz.id_regwr = 1'b1; hz.id_dst = 5'd4;
      #1;
`ifdef HAZARD_FORWARDING_EN
      chk("raw_fwd_en", en, RUN);
      chk("raw_fwd_a", hz.fwd_a, 1);
`else
      chk("raw_stall1", en, STALL);
      cyc(); exp_cnt++;
      chk("raw_stall2", en, STALL);
      chk("raw_cnt1", hz.stall_cnt, exp_cnt);
      cyc(); exp_cnt++;
      chk("raw_release", en, RUN);
      chk("raw_cnt2", hz.stall_cnt, exp_cnt);
`endif
      drain();

      // lw r5 ; add rt=r5
      producer(5'd5, 1'b1);
      cyc();
      idle();
      hz.id_rt = 5'd5;
      #1 chk("rt_unused", en, RUN);
      hz.id_use_rt = 1'b1; hz.id_regwr = 1'b1; hz.id_dst = 5'd6;
      #1 chk("loaduse_stall", en, STALL);
      cyc(); exp_cnt++;
`ifdef HAZARD_FORWARDING_EN
      chk("loaduse_release", en, RUN);
      chk("loaduse_fwd_b", hz.fwd_b, 2);
`else
      chk("loaduse_stall2", en, STALL);
      cyc(); exp_cnt++;
      chk("loaduse_release", en, RUN);
`endif
      chk("loaduse_cnt", hz.stall_cnt, exp_cnt);
      drain();

      // memory stall with a load-use hazard pending
      producer(5'd5, 1'b1);
      cyc();
      idle();
      hz.id_use_rt = 1'b1; hz.id_rt = 5'd5;
      hz.mem_dREN = 1'b1; hz.dhit = 1'b0;
      #1 chk("memstall_en", en, HOLD);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("memstall_hold_en", en, HOLD);
         chk("memstall_hold_cnt", hz.stall_cnt, exp_cnt);
      end
      hz.dhit = 1'b1;
      #1 chk("memstall_resume", en, STALL);
      cyc(); exp_cnt++;
      chk("memstall_cnt", hz.stall_cnt, exp_cnt);
      drain();
      hz.mem_dWEN = 1'b1; hz.dhit = 1'b0;
      #1 chk("store_stall_en", en, HOLD);
      idle();

      // branch taken in the same cycle as a load-use hazard
      producer(5'd7, 1'b1);
      cyc();
      idle();
      hz.id_use_rs = 1'b1; hz.id_rs = 5'd7; hz.id_regwr = 1'b1; hz.id_dst = 5'd9;
      hz.ex_taken = 1'b1;
      #1 chk("branch_en", en, BR);
      cyc();
      chk("branch_cnt", hz.stall_cnt, exp_cnt);
      idle();
      hz.id_use_rs = 1'b1; hz.id_rs = 5'd9;
      #1 chk("squashed_not_tracked", en, RUN);
      chk("squashed_fwd", hz.fwd_a, 0);
      drain();

      // r0 is never a dependency
      producer(5'd0, 1'b0);
      cyc();
      idle();
      hz.id_use_rs = 1'b1; hz.id_use_rt = 1'b1;
      #1 chk("r0_en", en, RUN);
      chk("r0_fwd", {hz.fwd_a, hz.fwd_b}, 0);
      idle();
      hz.ihit = 1'b0;
      #1 chk("ifetch_miss", en, NOI);
      drain();

      // saturate the stall counter
      for (int i = 0; i < 16; i++) begin
         producer(5'd10, 1'b1);
         cyc();
         idle();
         hz.id_use_rs = 1'b1; hz.id_rs = 5'd10;
         cyc(); cyc();
      end
      chk("sat_cnt", hz.stall_cnt, 15);
      producer(5'd10, 1'b1);
      cyc();
      idle();
      hz.id_use_rs = 1'b1; hz.id_rs = 5'd10;
      #1 chk("sat_stall_en", en, STALL);
      cyc();
      chk("sat_cnt_hold", hz.stall_cnt, 15);

      // halt with a producer entering alongside
      producer(5'd11, 1'b0);
      hz.wb_halt = 1'b1;
      #1 chk("halt_before_edge", hz.halted, 0);
      cyc();
      idle();
      chk("halted_set", hz.halted, 1);
      chk("halted_en", en, HOLD);
      hz.ex_taken = 1'b1;
      #1 chk("halted_beats_branch", en, HOLD);
      cyc();
      chk("halted_sticky", hz.halted, 1);
      chk("halted_cnt", hz.stall_cnt, 15);

      // asynchronous reset mid-run clears everything at once
      idle();
      rst = 1'b1;
      #1;
      chk("midreset_en", en, RSTV);
      chk("midreset_cnt", hz.stall_cnt, 0);
      chk("midreset_halted", hz.halted, 0);
      cyc();
      rst = 1'b0;
      hz.id_use_rs = 1'b1; hz.id_rs = 5'd11;
      #1 chk("postreset_no_stale", en, RUN);
      chk("postreset_fwd", hz.fwd_a, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
